// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: op and state encodings plus iteration count shared by the
// HI/LO multiply/divide sequencer.
package muldiv_sequencer_pkg;
    localparam logic [1:0] MulDivOp_Div   = 2'b00;
    localparam logic [1:0] MulDivOp_Divu  = 2'b01;
    localparam logic [1:0] MulDivOp_Mult  = 2'b10;
    localparam logic [1:0] MulDivOp_Multu = 2'b11;
    localparam logic [5:0] MulDivIter     = 6'd32;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic op_signed(input logic [1:0] op);
        return op == MulDivOp_Div || op == MulDivOp_Mult;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one restoring-division or shift-add-multiply iteration on a packed
// {upper, lower} accumulator. Multiply path exists only with MULDIV_MULT_EN.
module muldiv_step #(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_MULT_EN
    input  logic               i_mul,
`endif
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0]     w_top;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div;

    // Division: acc = {remainder, dividend/quotient}; the remainder never exceeds
    // 32 bits, so the modular 32-bit difference is exact whenever w_ge holds.
    assign w_top = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge  = w_top >= {1'b0, i_b};
    assign w_div = w_ge ? {w_top[WIDTH-1:0] - i_b, i_acc[WIDTH-2:0], 1'b1}
                        : {i_acc[2*WIDTH-2:0], 1'b0};

`ifdef MULDIV_MULT_EN
    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_b} : '0);
    assign o_acc = i_mul ? {w_sum, i_acc[WIDTH-1:1]} : w_div;
`else
    assign o_acc = w_div;
`endif
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 33-cycle DIV/DIVU (and MULT/MULTU when MULDIV_MULT_EN is defined)
// that owns the HI/LO pair; MTHI/MTLO writes are taken only while not busy.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic             IllegalOp,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic               r_neg, r_neg_rem, r_bz, r_busy, r_done, r_dbz, r_ill;
    logic               w_open, w_legal, w_accept, w_sgn;
    logic [WIDTH-1:0]   w_ma, w_mb, w_quo, w_rem, w_fix_hi, w_fix_lo;
    logic [2*WIDTH-1:0] w_step;

    assign w_open   = r_state == S_IDLE || r_state == S_DONE;
    assign w_accept = Start && w_open && w_legal;
    assign w_sgn    = op_signed(Op);
    assign w_ma     = (w_sgn && A[WIDTH-1]) ? -A : A;
    assign w_mb     = (w_sgn && B[WIDTH-1]) ? -B : B;
    assign w_quo    = r_acc[WIDTH-1:0];
    assign w_rem    = r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_MULT_EN
    logic               r_mul;
    logic [2*WIDTH-1:0] w_prod;

    assign w_legal  = 1'b1;
    assign w_prod   = r_neg ? -r_acc : r_acc;
    assign w_fix_hi = r_mul ? w_prod[2*WIDTH-1:WIDTH] : (r_neg_rem ? -w_rem : w_rem);
    assign w_fix_lo = r_mul ? w_prod[WIDTH-1:0] : r_bz ? '1 : r_neg ? -w_quo : w_quo;
`else
    assign w_legal  = !Op[1];
    assign w_fix_hi = r_neg_rem ? -w_rem : w_rem;
    assign w_fix_lo = r_bz ? '1 : r_neg ? -w_quo : w_quo;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_MULT_EN
        .i_mul (r_mul),
`endif
        .i_acc (r_acc),
        .i_b   (r_b),
        .o_acc (w_step)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_bz      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_ill     <= 1'b0;
`ifdef MULDIV_MULT_EN
            r_mul     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_ill  <= 1'b0;
            if (!r_busy && HiWe) r_hi <= WData;
            if (!r_busy && LoWe) r_lo <= WData;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_ill   <= Start && !w_legal;
                    if (w_accept) begin
                        // Multiply keeps the multiplier in the low half and adds the multiplicand.
                        r_acc     <= {{WIDTH{1'b0}}, Op[1] ? w_mb : w_ma};
                        r_b       <= Op[1] ? w_ma : w_mb;
                        r_neg     <= w_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_rem <= w_sgn && A[WIDTH-1];
                        r_bz      <= !Op[1] && B == '0;
`ifdef MULDIV_MULT_EN
                        r_mul     <= Op[1];
`endif
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == MulDivIter - 6'd1) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_dbz   <= r_bz;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign IllegalOp = r_ill;
    assign Hi        = r_hi;
    assign Lo        = r_lo;
endmodule
